// File: rtl/gf256_mat_sparvec_mac_if.sv
// rtl/gf256_mat_sparvec_mac_if.sv - control, x-list, H, preload and readout bus of the GF(2^8) mat x sparse-vec MAC
interface gf256_mat_sparvec_mac_if #(
    parameter int ROWS_BYTES = 104,
    parameter int N_COLS     = 126,
    parameter int WEIGHT     = 79,
    parameter int LANES      = 8
);
    localparam int W         = 8 * LANES;
    localparam int ROW_WORDS = (ROWS_BYTES + LANES - 1) / LANES;
    localparam int RA_W      = $clog2(ROW_WORDS);
    localparam int VA_W      = (WEIGHT > 1) ? $clog2(WEIGHT) : 1;
    localparam int POS_W     = $clog2(N_COLS) + 1;
    localparam int MA_W      = $clog2(N_COLS * ROW_WORDS);

    logic              i_start;
    logic              i_acc;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_vec_rd;
    logic [VA_W-1:0]   o_vec_addr;
    logic [POS_W+7:0]  i_vec;
    logic              o_mat_rd;
    logic [MA_W-1:0]   o_mat_addr;
    logic [W-1:0]      i_mat;
    logic              i_pre_wen;
    logic [RA_W-1:0]   i_pre_addr;
    logic [W-1:0]      i_pre_data;
    logic              i_res_rd;
    logic [RA_W-1:0]   i_res_addr;
    logic [W-1:0]      o_res;

    modport slave (
        input  i_start, i_acc, i_vec, i_mat, i_pre_wen, i_pre_addr, i_pre_data, i_res_rd, i_res_addr,
        output o_busy, o_done, o_err, o_vec_rd, o_vec_addr, o_mat_rd, o_mat_addr, o_res
    );

    modport master (
        output i_start, i_acc, i_vec, i_mat, i_pre_wen, i_pre_addr, i_pre_data, i_res_rd, i_res_addr,
        input  o_busy, o_done, o_err, o_vec_rd, o_vec_addr, o_mat_rd, o_mat_addr, o_res
    );
endinterface

// File: rtl/gf256_mat_sparvec_mac.sv
// rtl/gf256_mat_sparvec_mac.sv - y = (acc ? y : 0) ^ H*x over GF(2^8), H column-major, x as (pos,val) list
// Optional: GF_ZERO_SKIP_EN skips streaming of val==0 entries.
module gf256_mat_sparvec_mac #(
    parameter int ROWS_BYTES = 104,
    parameter int N_COLS     = 126,
    parameter int WEIGHT     = 79,
    parameter int LANES      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    gf256_mat_sparvec_mac_if.slave  bus
);
    localparam int W         = 8 * LANES;
    localparam int ROW_WORDS = (ROWS_BYTES + LANES - 1) / LANES;
    localparam int RA_W      = $clog2(ROW_WORDS);
    localparam int VA_W      = (WEIGHT > 1) ? $clog2(WEIGHT) : 1;
    localparam int POS_W     = $clog2(N_COLS) + 1;
    localparam int MA_W      = $clog2(N_COLS * ROW_WORDS);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, LATCH, STREAM, DRAIN, DONE} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    state_t            state_q, state_d;
    logic              acc_q, acc_d, err_q, err_d;
    logic [VA_W-1:0]   ent_q, ent_d;
    logic [RA_W-1:0]   k_q, k_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [7:0]        val_q, val_d;
    logic              s1_vld_q, s1_vld_d;
    logic [RA_W-1:0]   s1_k_q, s1_k_d;
    logic              s2_we_q, s2_we_d;
    logic [RA_W-1:0]   s2_k_q, s2_k_d;
    logic [W-1:0]      s2_data_q, s2_data_d;
    logic [W-1:0]      rd_q, rd_d;
    logic [W-1:0]      mem_q [ROW_WORDS];

    logic              busy, adv;
    logic              mem_we, mem_re;
    logic [RA_W-1:0]   mem_waddr, mem_raddr;
    logic [W-1:0]      mem_wdata;
    logic [POS_W-1:0]  vec_pos;
    logic [7:0]        vec_val;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        err_d     = err_q;
        ent_d     = ent_q;
        k_d       = k_q;
        pos_d     = pos_q;
        val_d     = val_q;
        adv       = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = s2_k_q;
        mem_raddr = k_q;
        mem_wdata = s2_data_q;
        busy      = (state_q != IDLE) && (state_q != DONE);
        vec_pos   = bus.i_vec[POS_W+7:8];
        vec_val   = bus.i_vec[7:0];
        s1_vld_d  = 1'b0;
        s1_k_d    = k_q;
        s2_we_d   = s1_vld_q;
        s2_k_d    = s1_k_q;
        // rd_q holds y word k and i_mat holds H word k in the cycle after the STREAM issue
        for (int l = 0; l < LANES; l++) begin
            s2_data_d[W-1-8*l -: 8] = rd_q[W-1-8*l -: 8] ^ gf_mul(bus.i_mat[W-1-8*l -: 8], val_q);
        end

        if (!busy && bus.i_pre_wen) begin
            mem_we    = 1'b1;
            mem_waddr = bus.i_pre_addr;
            mem_wdata = bus.i_pre_data;
        end
        if (s2_we_q) begin
            mem_we    = 1'b1;
            mem_waddr = s2_k_q;
            mem_wdata = s2_data_q;
        end
        if (!busy && bus.i_res_rd) begin
            mem_re    = 1'b1;
            mem_raddr = bus.i_res_addr;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    acc_d   = bus.i_acc;
                    err_d   = 1'b0;
                    ent_d   = '0;
                    k_d     = '0;
                    state_d = bus.i_acc ? FETCH : CLEAR;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = k_q;
                mem_wdata = '0;
                if (k_q == RA_W'(ROW_WORDS - 1)) begin
                    k_d     = '0;
                    state_d = FETCH;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                pos_d = vec_pos;
                val_d = vec_val;
                k_d   = '0;
                if (vec_pos >= POS_W'(N_COLS)) begin
                    err_d = 1'b1;
                    adv   = 1'b1;
                end
`ifdef GF_ZERO_SKIP_EN
                else if (vec_val == 8'h00) begin
                    adv = 1'b1;
                end
`endif
                else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                mem_re    = 1'b1;
                mem_raddr = k_q;
                s1_vld_d  = 1'b1;
                s1_k_d    = k_q;
                if (k_q == RA_W'(ROW_WORDS - 1)) adv = 1'b1;
                else k_d = k_q + 1'b1;
            end
            DRAIN: begin
                if (k_q == RA_W'(1)) state_d = DONE;
                else k_d = k_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (adv) begin
            k_d = '0;
            if (ent_q == VA_W'(WEIGHT - 1)) begin
                state_d = DRAIN;
            end else begin
                ent_d   = ent_q + 1'b1;
                state_d = FETCH;
            end
        end

        // write-first: a read of the word being written this cycle returns the new data
        rd_d = rd_q;
        if (mem_re) begin
            rd_d = (mem_we && (mem_waddr == mem_raddr)) ? mem_wdata : mem_q[mem_raddr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            err_q     <= 1'b0;
            ent_q     <= '0;
            k_q       <= '0;
            pos_q     <= '0;
            val_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_k_q    <= '0;
            s2_we_q   <= 1'b0;
            s2_k_q    <= '0;
            s2_data_q <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            ent_q     <= ent_d;
            k_q       <= k_d;
            pos_q     <= pos_d;
            val_q     <= val_d;
            s1_vld_q  <= s1_vld_d;
            s1_k_q    <= s1_k_d;
            s2_we_q   <= s2_we_d;
            s2_k_q    <= s2_k_d;
            s2_data_q <= s2_data_d;
            rd_q      <= rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.o_busy     = busy;
    assign bus.o_done     = (state_q == DONE);
    assign bus.o_err      = err_q;
    assign bus.o_vec_rd   = (state_q == FETCH);
    assign bus.o_vec_addr = ent_q;
    assign bus.o_mat_rd   = (state_q == STREAM);
    assign bus.o_mat_addr = MA_W'(pos_q) * MA_W'(ROW_WORDS) + MA_W'(k_q);
    assign bus.o_res      = rd_q;
endmodule

// File: tb/tb_gf256_mat_sparvec_mac.sv
// tb/tb_gf256_mat_sparvec_mac.sv - table-driven self-checking bench with result scoreboard
module tb_gf256_mat_sparvec_mac;
    localparam int ROWS_BYTES = 16;
    localparam int N_COLS     = 8;
    localparam int WEIGHT     = 3;
    localparam int LANES      = 8;
    localparam int RW         = 2;
    localparam int W          = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf256_mat_sparvec_mac_if #(.ROWS_BYTES(ROWS_BYTES), .N_COLS(N_COLS), .WEIGHT(WEIGHT), .LANES(LANES)) bus ();
    gf256_mat_sparvec_mac #(.ROWS_BYTES(ROWS_BYTES), .N_COLS(N_COLS), .WEIGHT(WEIGHT), .LANES(LANES)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       acc;
        logic [7:0] pre;
        logic [3:0] pos [3];
        logic [7:0] val [3];
        logic       exp_err;
    } vec_t;

    vec_t         tv [6];
    logic [11:0]  vmem [4];
    logic [W-1:0] sb_q [$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           done_cnt = 0;

    function automatic logic [7:0] gfm(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] hbyte(input int c, input int b);
        if (c == 2) return 8'h03;
        if (c == 5) return 8'h80;
        return 8'(c * 37 + 17) ^ 8'(b);
    endfunction

    function automatic logic [W-1:0] hword(input int addr);
        logic [W-1:0] w;
        for (int l = 0; l < LANES; l++) w[W-1-8*l -: 8] = hbyte(addr / RW, (addr % RW) * LANES + l);
        return w;
    endfunction

    always @(posedge clk) begin
        if (bus.o_vec_rd) bus.i_vec <= vmem[bus.o_vec_addr];
        if (bus.o_mat_rd) bus.i_mat <= hword(int'(bus.o_mat_addr));
    end

    always @(negedge clk) if (bus.o_done) done_cnt++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setup(input int idx, output int exp_cyc);
        logic [7:0]   y;
        logic [W-1:0] w;
        logic         skip;
`ifdef GF_ZERO_SKIP_EN
        skip = 1'b1;
`else
        skip = 1'b0;
`endif
        for (int e = 0; e < WEIGHT; e++) vmem[e] = {tv[idx].pos[e], tv[idx].val[e]};
        for (int k = 0; k < RW; k++) begin
            @(negedge clk);
            bus.i_pre_wen  = 1'b1;
            bus.i_pre_addr = 1'(k);
            bus.i_pre_data = {LANES{tv[idx].pre}};
        end
        @(negedge clk);
        bus.i_pre_wen = 1'b0;
        for (int k = 0; k < RW; k++) begin
            for (int l = 0; l < LANES; l++) begin
                y = tv[idx].acc ? tv[idx].pre : 8'h00;
                for (int e = 0; e < WEIGHT; e++)
                    if (tv[idx].pos[e] < N_COLS) y = y ^ gfm(hbyte(int'(tv[idx].pos[e]), k * LANES + l), tv[idx].val[e]);
                w[W-1-8*l -: 8] = y;
            end
            sb_q.push_back(w);
        end
        exp_cyc = tv[idx].acc ? 0 : RW;
        for (int e = 0; e < WEIGHT; e++)
            exp_cyc += (tv[idx].pos[e] >= N_COLS || (skip && tv[idx].val[e] == 8'h00)) ? 2 : RW + 2;
        exp_cyc += 3;
    endtask

    task automatic run_vec(input int idx, input bit disturb);
        int exp_cyc;
        int n;
        int d0;
        bit got;
        setup(idx, exp_cyc);
        d0 = done_cnt;
        bus.i_start = 1'b1;
        bus.i_acc   = tv[idx].acc;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_acc   = ~tv[idx].acc;
        n = 1;
        chk($sformatf("v%0d busy_after_start", idx), W'(bus.o_busy), W'(1));
        got = 1'b0;
        while (n < 200) begin
            if (bus.o_done) begin
                got = 1'b1;
                break;
            end
            if (disturb && n == 4) begin
                bus.i_start    = 1'b1;
                bus.i_pre_wen  = 1'b1;
                bus.i_pre_addr = 1'b0;
                bus.i_pre_data = '1;
                bus.i_res_rd   = 1'b1;
                bus.i_res_addr = 1'b0;
            end
            @(negedge clk);
            bus.i_start   = 1'b0;
            bus.i_pre_wen = 1'b0;
            bus.i_res_rd  = 1'b0;
            n++;
        end
        chk($sformatf("v%0d done_cycle", idx), W'(got ? n : 999), W'(exp_cyc));
        chk($sformatf("v%0d err", idx), W'(bus.o_err), W'(tv[idx].exp_err));
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_end", idx), W'(bus.o_done), W'(0));
        chk($sformatf("v%0d busy_end", idx), W'(bus.o_busy), W'(0));
        chk($sformatf("v%0d done_count", idx), W'(done_cnt - d0), W'(1));
        for (int k = 0; k < RW; k++) begin
            bus.i_res_rd   = 1'b1;
            bus.i_res_addr = 1'(k);
            @(negedge clk);
            bus.i_res_rd = 1'b0;
            if (sb_q.size() > 0) chk($sformatf("v%0d result_word%0d", idx, k), bus.o_res, sb_q.pop_front());
            else chk("scoreboard_empty", W'(sb_q.size()), W'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int exp_cyc;
        tv[0] = '{acc: 1'b0, pre: 8'h3C, pos: '{4'd2, 4'd5, 4'd7},  val: '{8'h01, 8'h02, 8'h00}, exp_err: 1'b0};
        tv[1] = '{acc: 1'b1, pre: 8'hFF, pos: '{4'd2, 4'd5, 4'd7},  val: '{8'h01, 8'h02, 8'h00}, exp_err: 1'b0};
        tv[2] = '{acc: 1'b0, pre: 8'h3C, pos: '{4'd2, 4'd8, 4'd5},  val: '{8'h01, 8'h55, 8'h02}, exp_err: 1'b1};
        tv[3] = '{acc: 1'b0, pre: 8'h77, pos: '{4'd0, 4'd0, 4'd6},  val: '{8'h83, 8'h83, 8'h02}, exp_err: 1'b0};
        tv[4] = '{acc: 1'b1, pre: 8'h5A, pos: '{4'd7, 4'd3, 4'd1},  val: '{8'h01, 8'h00, 8'hC5}, exp_err: 1'b0};
        tv[5] = '{acc: 1'b1, pre: 8'h00, pos: '{4'd4, 4'd15, 4'd4}, val: '{8'hFF, 8'h01, 8'hFE}, exp_err: 1'b1};

        bus.i_start = 1'b0; bus.i_acc = 1'b0; bus.i_pre_wen = 1'b0; bus.i_pre_addr = '0;
        bus.i_pre_data = '0; bus.i_res_rd = 1'b0; bus.i_res_addr = '0;
        bus.i_vec = '0; bus.i_mat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset o_busy",   W'(bus.o_busy),   W'(0));
        chk("reset o_done",   W'(bus.o_done),   W'(0));
        chk("reset o_err",    W'(bus.o_err),    W'(0));
        chk("reset o_vec_rd", W'(bus.o_vec_rd), W'(0));
        chk("reset o_mat_rd", W'(bus.o_mat_rd), W'(0));
        chk("reset o_res",    bus.o_res,        W'(0));

        for (int i = 0; i < 6; i++) run_vec(i, 1'b0);
        run_vec(0, 1'b1);

        // abort a run with reset while streaming the first entry
        setup(0, exp_cyc);
        sb_q.delete();
        bus.i_start = 1'b1;
        bus.i_acc   = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort in_stream", W'(bus.o_mat_rd), W'(1));
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy_low", W'(bus.o_busy), W'(0));
        repeat (25) @(negedge clk);
        chk("abort no_done", W'(done_cnt - d0), W'(0));
        run_vec(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
